// File: rtl/control_pkg.sv
// control_pkg: shared types and encodings for the multicycle RV32I control unit.
//   - state_t   : sequencer states
//   - alu_op_t  : coarse ALU request from the sequencer to alu_decoder
//   - opcode, alu_control and mux-select encodings used by the datapath
//   - imm_src_of: immediate format selected from the opcode
package control_pkg;

  typedef enum logic [3:0] {
    FETCH, FETCH2, DECODE, MEMADR, MEMREAD, MEMWAIT, MEMWB,
    MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BRANCH
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_DMEM       = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the sequencer's coarse ALU request plus instruction
// function fields onto the datapath alu_control encoding.
//   alu_op      in  : ADD / SUB forced by the sequencer, or FUNCT decode
//   funct3      in  : instruction bits [14:12]
//   funct7_5    in  : instruction bit 30
//   op_code_5   in  : opcode bit 5 (1 = R-type, 0 = I-type ALU)
//   alu_control out : operation for the ALU
module alu_decoder
  import control_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_code_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7[5] only means sub for R-type; in addi it is immediate bit.
          3'b000:  alu_control = (op_code_5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the multicycle RV32I datapath.
//   clk, reset (sync, active-low)
//   op_code/funct3/funct7 : fields of the instruction register
//   Zero                  : ALU zero flag (used in BRANCH)
//   adr_src, result_src, alu_src_a, alu_src_b, imm_src, alu_control : selects
//   mem_write, IR_write, reg_write, PC_write : write enables
//   illegal : pulse in DECODE for an unsupported opcode
//   retire  : pulse in the last state of every instruction
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  output logic       adr_src,
  output logic       mem_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       PC_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic       retire
);

  state_t  state, next_state;
  alu_op_t alu_op;
  logic    mem_write_raw, ir_write_raw, reg_write_raw, pc_write_raw;
  logic    illegal_raw, retire_raw;
  logic    branch_taken;

  // Only funct7[5] participates in decoding.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = ~Zero;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = FETCH2;
      FETCH2: next_state = DECODE;
      DECODE: begin
        case (op_code)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECUTER;
          OP_ITYPE:          next_state = EXECUTEI;
          OP_JAL:            next_state = JAL;
          OP_BRANCH:         next_state = BRANCH;
          default:           next_state = FETCH;
        endcase
      end
      // Bit 5 separates sw (0100011) from lw (0000011).
      MEMADR:   next_state = op_code[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = MEMWAIT;
      MEMWAIT:  next_state = MEMWB;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      JAL:      next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    adr_src       = ADR_PC;
    result_src    = RES_ALU_OUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    pc_write_raw  = 1'b0;
    illegal_raw   = 1'b0;
    retire_raw    = 1'b0;
    case (state)
      FETCH: adr_src = ADR_PC;
      FETCH2: begin
        ir_write_raw = 1'b1;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALU_RESULT;
        pc_write_raw = 1'b1;
      end
      DECODE: begin
        // Precompute the branch/jal target into ALU_out.
        alu_src_a = SRCA_OLD_PC;
        alu_src_b = SRCB_IMM;
        case (op_code)
          OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH: ;
          default: begin
            illegal_raw = 1'b1;
            retire_raw  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD, MEMWAIT: adr_src = ADR_RESULT;
      MEMWB: begin
        result_src    = RES_DMEM;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      MEMWRITE: begin
        adr_src       = ADR_RESULT;
        mem_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      JAL: begin
        alu_src_a    = SRCA_OLD_PC;
        alu_src_b    = SRCB_FOUR;
        pc_write_raw = 1'b1;
      end
      BRANCH: begin
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALUOP_SUB;
        pc_write_raw = branch_taken;
        retire_raw   = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7[5]),
    .op_code_5   (op_code[5]),
    .alu_control (alu_control)
  );

  assign imm_src = imm_src_of(op_code);

  // While reset is low no side effect may escape, whatever the state register holds.
  assign mem_write = reset & mem_write_raw;
  assign IR_write  = reset & ir_write_raw;
  assign reg_write = reset & reg_write_raw;
  assign PC_write  = reset & pc_write_raw;
  assign illegal   = reset & illegal_raw;
  assign retire    = reset & retire_raw;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       adr_src, mem_write, IR_write, reg_write, PC_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       illegal, retire;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int cyc    = 0;
  logic [17:0] exp_q[$];

  control_unit dut (
    .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .adr_src(adr_src), .mem_write(mem_write), .IR_write(IR_write),
    .reg_write(reg_write), .PC_write(PC_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .illegal(illegal), .retire(retire)
  );

  always #5 clk = ~clk;

  // Observed control word, same field order as the model's w().
  function automatic logic [17:0] obs_word();
    return {adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
            alu_src_a, alu_src_b, imm_src, alu_control, illegal, retire};
  endfunction

  function automatic logic [17:0] w(bit adr, bit mw, bit irw, bit rw, bit pcw,
                                    logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                    logic [1:0] imm, logic [2:0] alu, bit ill, bit ret);
    return {adr, mw, irw, rw, pcw, rs, sa, sb, imm, alu, ill, ret};
  endfunction

  function automatic logic [1:0] ref_imm(logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] ref_funct_op(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    case (f3)
      3'b000:  return (op[5] && f7[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Reference model: the per-cycle control words an instruction must produce.
  task automatic push_expected(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, bit z);
    logic [1:0] im;
    bit legal, taken;
    im = ref_imm(op);
    legal = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
            (op == 7'b0010011) || (op == 7'b1101111) || (op == 7'b1100011);
    exp_q.push_back(w(0,0,0,0,0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 0));
    exp_q.push_back(w(0,0,1,0,1, 2'b10, 2'b00, 2'b10, im, 3'b000, 0, 0));
    exp_q.push_back(w(0,0,0,0,0, 2'b00, 2'b01, 2'b01, im, 3'b000, !legal, !legal));
    case (op)
      7'b0000011: begin
        exp_q.push_back(w(0,0,0,0,0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0, 0));
        exp_q.push_back(w(1,0,0,0,0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 0));
        exp_q.push_back(w(1,0,0,0,0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 0));
        exp_q.push_back(w(0,0,0,1,0, 2'b01, 2'b00, 2'b00, im, 3'b000, 0, 1));
      end
      7'b0100011: begin
        exp_q.push_back(w(0,0,0,0,0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0, 0));
        exp_q.push_back(w(1,1,0,0,0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 1));
      end
      7'b0110011, 7'b0010011: begin
        exp_q.push_back(w(0,0,0,0,0, 2'b00, 2'b10, op[5] ? 2'b00 : 2'b01, im,
                          ref_funct_op(op, f3, f7), 0, 0));
        exp_q.push_back(w(0,0,0,1,0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 1));
      end
      7'b1101111: begin
        exp_q.push_back(w(0,0,0,0,1, 2'b00, 2'b01, 2'b10, im, 3'b000, 0, 0));
        exp_q.push_back(w(0,0,0,1,0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 1));
      end
      7'b1100011: begin
        taken = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
        exp_q.push_back(w(0,0,0,0,taken, 2'b00, 2'b10, 2'b00, im, 3'b001, 0, 1));
      end
      default: ;
    endcase
  endtask

  // Scoreboard monitor: one expected word consumed per observed cycle.
  always @(negedge clk) begin
    logic [17:0] e, o;
    if (mon_en) begin
      cyc++;
      o = obs_word();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow cycle %0d got %b required no output", cyc, o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL ctrl_word cycle %0d op %b f3 %b got %b required %b",
                   cyc, op_code, funct3, o, e);
        end
      end
    end
  end

  // Issue one instruction (DUT in FETCH), wait for its retire, return in FETCH.
  task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, bit z);
    int n;
    op_code = op; funct3 = f3; funct7 = f7; Zero = z;
    push_expected(op, f3, f7, z);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (retire !== 1'b1 && n < 12);
    if (n >= 12) begin
      checks++; errors++;
      $display("FAIL retire_timeout op %b got no retire within %0d cycles required retire", op, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic check(string name, logic [17:0] got, logic [17:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %b required %b", name, got, req);
    end
  endtask

  initial begin
    logic [6:0] ops[7];
    logic [6:0] op, f7;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b1100011, 7'b0000000};
    reset = 1'b0; op_code = '0; funct3 = '0; funct7 = '0; Zero = 1'b0;

    // Reset held low for two edges: no enables or pulses may appear.
    repeat (2) begin
      @(negedge clk);
      check("reset_quiet", {12'b0, mem_write, IR_write, reg_write, PC_write, illegal, retire}, 18'b0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b1;

    // Directed instructions from the test plan.
    run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0); // sub
    run_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0); // lw
    run_instr(7'b1100011, 3'b001, 7'b0000000, 1'b1); // bne, not taken
    run_instr(7'b1100011, 3'b001, 7'b0000000, 1'b0); // bne, taken
    run_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1); // beq, taken
    run_instr(7'b1101111, 3'b101, 7'b1010101, 1'b0); // jal
    run_instr(7'b0000000, 3'b000, 7'b0000000, 1'b0); // illegal
    run_instr(7'b0010011, 3'b000, 7'b0100000, 1'b0); // addi with bit30 set
    run_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0); // sw

    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 6)];
      f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom);
      run_instr(op, 3'($urandom), f7, 1'($urandom));
    end

    @(negedge clk);
    mon_en = 1'b0;
    exp_q.delete();
    @(posedge clk); #1; // back at instruction start boundary plus one; realign below

    // Abort a store: reset asserted while in MEMWRITE.
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    op_code = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0; Zero = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_memwrite", {12'b0, mem_write, IR_write, reg_write, PC_write, illegal, retire}, 18'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_fetch", obs_word(), w(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0));
    @(negedge clk);
    check("abort_fetch2", obs_word(), w(0,0,1,0,1, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle sequencer for the RV32I subset executed by the datapath: decodes `op_code`/`funct3`/`funct7`, steps a Moore FSM through fetch/decode/execute/memory/writeback, and drives every datapath mux select and write enable. Sits beside the datapath in the top level; its outputs connect 1:1 to the datapath control inputs. Supported: R-type ALU, I-type ALU, `lw`, `sw`, `beq`, `bne`, `jal`. Both memories have 1-cycle registered reads.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low.
- `op_code` in 7: instruction bits [6:0].
- `funct3` in 3: instruction bits [14:12].
- `funct7` in 7: instruction bits [31:25].
- `Zero` in 1: ALU zero flag.
- `adr_src` out 1: 0 = PC, 1 = result.
- `mem_write`, `IR_write`, `reg_write`, `PC_write` out 1 each: write enables.
- `result_src` out 2: 00 ALU_out, 01 dmem_data, 10 ALU_result.
- `alu_src_a` out 2: 00 PC, 01 old_PC, 10 rs1 reg.
- `alu_src_b` out 2: 00 rs2 reg, 01 imm, 10 const 4.
- `imm_src` out 2: 00 I, 01 S, 10 B, 11 J.
- `alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `illegal` out 1: 1-cycle pulse in DECODE on unsupported opcode.
- `retire` out 1: 1-cycle pulse in the final state of each instruction.

## Operation
- Per-state outputs; unlisted enables = 0, unlisted selects = 00.
- FETCH: adr_src=0; imem samples PC. -> FETCH2.
- FETCH2: IR_write=1; src_a=00, src_b=10, add, result_src=10, PC_write=1. -> DECODE.
- DECODE: src_a=01, src_b=01, add (branch/jal target into ALU_out). By opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BRANCH; else `illegal`=1, `retire`=1, -> FETCH.
- MEMADR: src_a=10, src_b=01, add. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. -> MEMWAIT.
- MEMWAIT: adr_src=1, result_src=00. -> MEMWB.
- MEMWB: result_src=01, reg_write=1, retire. -> FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, retire. -> FETCH.
- EXECUTER: src_a=10, src_b=00, funct ALU op. -> ALUWB.
- EXECUTEI: src_a=10, src_b=01, funct ALU op. -> ALUWB.
- ALUWB: result_src=00, reg_write=1, retire. -> FETCH.
- JAL: src_a=01, src_b=10, add, result_src=00, PC_write=1. -> ALUWB.
- BRANCH: src_a=10, src_b=00, sub, result_src=00; PC_write = Zero (funct3 000) or !Zero (funct3 001); other funct3 -> PC_write=0. retire. -> FETCH.
- `imm_src` combinational from opcode: lw/I-ALU 00, sw 01, branch 10, jal 11, else 00.
- Funct ALU op: funct3 000 -> sub if op_code[5] & funct7[5] else add; 010 slt; 110 or; 111 and; others -> add (no trap).

## Timing
- Reset: reset low at a rising edge -> state = FETCH next cycle; while reset low, all write enables, `illegal`, `retire` forced 0 combinationally, independent of state. Selects don't-care.
- Reset mid-instruction aborts; no partial register/memory write after the reset edge.
- Cycles per instruction: R/I 5, lw 7, sw 5, branch 4, jal 5, illegal 3.
- IR and old_PC update only at end of FETCH2; PC only in FETCH2, JAL, taken BRANCH.
- Exactly one `retire` per instruction; never in the same cycle as reset low.

## Structure
- Package `control_pkg`: state enum (FETCH, FETCH2, DECODE, MEMADR, MEMREAD, MEMWAIT, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BRANCH), opcode constants, alu_control constants, select encodings.
- Sub-module `alu_decoder`: combinational {alu_op, funct3, funct7[5], op_code[5]} -> alu_control.
- Top holds state register, next-state logic, output decode.

## Test plan
- Reset low 2 cycles then high -> FETCH, all enables 0 during reset; first IR_write in cycle 2 after release.
- op 0110011, funct3 000, funct7 0100000 (sub) -> states FETCH,FETCH2,DECODE,EXECUTER,ALUWB; alu_control=001 in EXECUTER; reg_write=1 only in ALUWB.
- op 0000011 (lw) -> 7-cycle sequence; adr_src=1 in MEMREAD/MEMWAIT; result_src=01 with reg_write=1 in MEMWB; retire once.
- op 1100011 funct3 001, Zero=1 -> PC_write=0; Zero=0 -> PC_write=1; both retire in cycle 4.
- op 1101111 -> PC_write in FETCH2 and JAL, imm_src=11, ALUWB writes; op 0000000 -> illegal pulse in DECODE, back to FETCH.
- Reset asserted during MEMWRITE -> mem_write=0 that cycle, FETCH next.
